// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD coprocessor: FSM encoding, algorithm selectors
// and the width of the Stein common-power-of-two counter.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ALGO_STEIN  = 0;
    localparam int ALGO_EUCLID = 1;

    // k never exceeds WIDTH-1, so clog2(WIDTH+1) bits always hold it.
    function automatic int k_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gcd_step.sv
// Combinational single reduction step of the GCD iteration; ALGO picks binary
// (Stein) or subtractive Euclid. term/result describe the current a/b pair.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ALGO  = ALGO_STEIN,
    parameter int KW    = k_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic [KW-1:0]    k_next,
    output logic             term,
    output logic [WIDTH-1:0] result
);

    generate
        if (ALGO == ALGO_STEIN) begin : g_stein
            always_comb begin
                a_next = a;
                b_next = b;
                k_next = k;
                term   = (a == '0) || (b == '0);
                result = (a | b) << k;
                if (!a[0] && !b[0]) begin
                    a_next = a >> 1;
                    b_next = b >> 1;
                    k_next = k + KW'(1);
                end else if (!a[0]) begin
                    a_next = a >> 1;
                end else if (!b[0]) begin
                    b_next = b >> 1;
                end else if (a >= b) begin
                    a_next = (a - b) >> 1;
                end else begin
                    b_next = (b - a) >> 1;
                end
            end
        end else begin : g_euclid
            // A zero operand or equal operands both finish with a|b as the answer.
            always_comb begin
                a_next = a;
                b_next = b;
                k_next = k;
                term   = (a == '0) || (b == '0) || (a == b);
                result = a | b;
                if (a > b) begin
                    a_next = a - b;
                end else begin
                    b_next = b - a;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/gcd_engine.sv
// GCD coprocessor: valid/ready operand port, one reduction step per clock,
// result held on a valid/ready port until the consumer takes it.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ALGO  = ALGO_STEIN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] steps_out,
    output logic             zero_flag
);

    localparam int KW = k_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] b_step;
    logic [KW-1:0]    k_step;
    logic             step_term;
    logic [WIDTH-1:0] step_result;
    logic [CNT_W-1:0] steps_reg;
    logic [WIDTH-1:0] gcd_reg;
    logic             zero_reg;

    gcd_step #(
        .WIDTH(WIDTH),
        .ALGO (ALGO),
        .KW   (KW)
    ) u_step (
        .a     (a_reg),
        .b     (b_reg),
        .k     (k_reg),
        .a_next(a_step),
        .b_next(b_step),
        .k_next(k_step),
        .term  (step_term),
        .result(step_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_CALC;
            ST_CALC: if (step_term) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Result registers only change on accept and on the terminating CALC cycle,
    // which keeps them stable for the whole DONE phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            k_reg     <= '0;
            steps_reg <= '0;
            gcd_reg   <= '0;
            zero_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        k_reg     <= '0;
                        steps_reg <= '0;
                        zero_reg  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (step_term) begin
                        gcd_reg  <= step_result;
                        zero_reg <= (a_reg == '0) && (b_reg == '0);
                    end else begin
                        a_reg <= a_step;
                        b_reg <= b_step;
                        k_reg <= k_step;
                        if (steps_reg != {CNT_W{1'b1}}) begin
                            steps_reg <= steps_reg + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign gcd_out   = gcd_reg;
    assign steps_out = steps_reg;
    assign zero_flag = zero_reg;

endmodule
